// File: rtl/queue4_rtl.sv
// queue4_rtl: 4-entry valid/ready FIFO with a pointer-selected 4:1 dequeue mux.
// Optional macro QUEUE4_PIPE_EN lets a full queue accept an entry while dequeuing.
module queue4_rtl #(
  parameter int p_nbits = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enq_val,
  output logic               enq_rdy,
  input  logic [p_nbits-1:0] enq_msg,
  output logic               deq_val,
  input  logic               deq_rdy,
  output logic [p_nbits-1:0] deq_msg,
  output logic [2:0]         count
);

  logic [p_nbits-1:0] entries_q [4];
  logic [p_nbits-1:0] entries_d [4];
  logic [1:0]         enq_ptr_q, enq_ptr_d;
  logic [1:0]         deq_ptr_q, deq_ptr_d;
  logic [2:0]         count_q, count_d;
  logic               enq_xfer, deq_xfer;

  assign deq_val = (count_q != 3'd0);
  assign deq_msg = entries_q[deq_ptr_q];
  assign count   = count_q;

`ifdef QUEUE4_PIPE_EN
  // A full queue can take a new entry into the slot being freed this cycle.
  assign enq_rdy = (count_q != 3'd4) | deq_rdy;
`else
  assign enq_rdy = (count_q != 3'd4);
`endif

  assign enq_xfer = enq_val & enq_rdy;
  assign deq_xfer = deq_val & deq_rdy;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      entries_d[i] = entries_q[i];
    end
    enq_ptr_d = enq_ptr_q;
    deq_ptr_d = deq_ptr_q;
    count_d   = count_q;

    if (enq_xfer) begin
      entries_d[enq_ptr_q] = enq_msg;
      enq_ptr_d            = enq_ptr_q + 2'd1;
    end
    if (deq_xfer) begin
      deq_ptr_d = deq_ptr_q + 2'd1;
    end

    if (enq_xfer && !deq_xfer) begin
      count_d = count_q + 3'd1;
    end else if (deq_xfer && !enq_xfer) begin
      count_d = count_q - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        entries_q[i] <= '0;
      end
      enq_ptr_q <= 2'd0;
      deq_ptr_q <= 2'd0;
      count_q   <= 3'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        entries_q[i] <= entries_d[i];
      end
      enq_ptr_q <= enq_ptr_d;
      deq_ptr_q <= deq_ptr_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: doc/queue4_rtl.md
Name: queue4_rtl

Overview:
- 4-entry, p_nbits-wide FIFO queue with valid/ready handshakes on the enqueue and dequeue sides.
- Storage is four registers. The dequeue data path is a 4:1 mux selected by the 2-bit dequeue pointer, so this block feeds the team's 4-input mux directly.
- Used as the buffering stage in front of memory request/response paths in the lab datapath.

Parameters:
- p_nbits, 32, width of each queue entry and of enq_msg/deq_msg.

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- enq_val  input  1  producer presents valid data on enq_msg
- enq_rdy  output  1  queue can accept an entry this cycle
- enq_msg  input  p_nbits  enqueue data
- deq_val  output  1  queue holds at least one entry
- deq_rdy  input  1  consumer accepts deq_msg this cycle
- deq_msg  output  p_nbits  oldest entry (entries[deq_ptr])
- count  output  3  number of valid entries, 0..4

Behaviour:
- State: entries[0..3] (p_nbits each), enq_ptr[1:0], deq_ptr[1:0], count[2:0].
- Reset (reset==0, async):
  - enq_ptr, deq_ptr, count and all entries go to 0 immediately, without waiting for a clock edge.
  - Outputs during and after reset: enq_rdy=1, deq_val=0, deq_msg=0, count=0.
- Transfers:
  - enq_xfer = enq_val & enq_rdy.
  - deq_xfer = deq_val & deq_rdy.
  - Both take effect on the rising edge.
- Enqueue: on enq_xfer, entries[enq_ptr] <= enq_msg and enq_ptr <= enq_ptr+1 (mod 4, natural 2-bit wrap).
- Dequeue: on deq_xfer, deq_ptr <= deq_ptr+1 (mod 4). The entry is not cleared.
- count:
  - +1 on enq_xfer only
  - -1 on deq_xfer only
  - unchanged when both or neither occur
- Combinational outputs:
  - deq_val = (count != 0)
  - deq_msg = entries[deq_ptr], always driven, even when empty
  - enq_rdy = (count != 4) in the base configuration
- Latency: an entry enqueued at edge N is visible on deq_msg with deq_val=1 from edge N onward. Minimum enqueue-to-dequeue latency is 1 cycle; there is no combinational bypass from enq_msg to deq_msg.
- Empty (count=0):
  - deq_val=0; deq_rdy is ignored.
  - Simultaneous enq_xfer gives count=1 next cycle.
- Full (count=4):
  - enq_rdy=0 (base); enq_val is ignored and storage is unchanged.
- Simultaneous enq_xfer and deq_xfer with 0<count<4: both pointers advance and count is unchanged.
- Wrap-around: pointers roll 3→0 with no special handling; ordering is strictly FIFO.
- Handshake rule: producer holds enq_msg stable while enq_val=1 and enq_rdy=0. The queue does not depend on this for correctness.
- Reset mid-operation: all entries are discarded. Any transfer in the cycle reset asserts is lost.
- No X propagation: all outputs are defined from reset onward.

Optional Feature:
- Macro: QUEUE4_PIPE_EN
- Defined: enq_rdy = (count != 4) | deq_rdy.
  - When full and the consumer dequeues, a new entry is accepted in the same cycle.
  - Write goes to entries[enq_ptr], which equals the slot being freed.
  - count stays 4.
  - This creates a combinational path deq_rdy→enq_rdy.
- Undefined: enq_rdy = (count != 4). No deq_rdy→enq_rdy path exists.

Test Plan:
- Reset then idle: hold reset=0 for 2 cycles, release, hold enq_val=0 and deq_rdy=0 -> count=0, deq_val=0, enq_rdy=1, deq_msg=0.
- Fill then drain (p_nbits=32):
  - Enqueue 0x11, 0x22, 0x33, 0x44 with deq_rdy=0 -> count=4, enq_rdy=0 (macro off), deq_msg=0x11.
  - Then deq_rdy=1 for 4 cycles -> deq_msg sequence 0x11, 0x22, 0x33, 0x44, then count=0, deq_val=0.
- Full rejection: with queue full, present enq_val=1, enq_msg=0x55, deq_rdy=0 for 3 cycles -> count stays 4; after draining, 0x55 never appears.
- Simultaneous enq/deq and wrap:
  - Preload 2 entries (0xA0, 0xA1).
  - For 6 cycles, enqueue 0xB0..0xB5 while dequeuing each cycle -> count stays 2; pointers wrap past 3.
  - Dequeued order is 0xA0, 0xA1, 0xB0..0xB3; remaining are 0xB4, 0xB5.
- Async reset mid-operation: with count=3, drive reset=0 between clock edges -> count, deq_val and deq_msg go to 0, 0, 0 before the next edge; the next enqueue of 0x77 lands in entry 0.
- QUEUE4_PIPE_EN defined:
  - Full with head 0x11: assert deq_rdy=1 and enq_val=1 with enq_msg=0x99 -> enq_rdy=1 the same cycle; count stays 4.
  - Draining then yields 0x22, 0x33, 0x44, 0x99.
